// File: rtl/countdown_mmss.sv
// MM:SS BCD countdown timer with load/start/stop control and a tick-driven decrement.
// Emits a one-cycle done pulse at 00:00 and a one-cycle load_err pulse when a load is rejected.
module countdown_mmss #(
  parameter logic [7:0] MAX_MIN = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] q_min,
  output logic [7:0] q_sec,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e     state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       preset_ok;
  logic       count_zero;
  logic       last_tick;
  logic [3:0] s0_dec, s1_dec, m0_dec, m1_dec;
  logic       b0, b1, b2;

  // BCD range check, including the minutes upper bound.
  assign preset_ok = (preset_min[7:4] <= 4'd9) && (preset_min[3:0] <= 4'd9) &&
                     (preset_sec[7:4] <= 4'd5) && (preset_sec[3:0] <= 4'd9) &&
                     (preset_min <= MAX_MIN);

  assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
  assign last_tick  = (min_q == 8'h00) && (sec_q == 8'h01);

  // Ripple-borrow decrement across the four BCD digits.
  always_comb begin
    b0     = (sec_q[3:0] == 4'd0);
    s0_dec = b0 ? 4'd9 : sec_q[3:0] - 4'd1;
    b1     = b0 && (sec_q[7:4] == 4'd0);
    s1_dec = b0 ? ((sec_q[7:4] == 4'd0) ? 4'd5 : sec_q[7:4] - 4'd1) : sec_q[7:4];
    b2     = b1 && (min_q[3:0] == 4'd0);
    m0_dec = b1 ? ((min_q[3:0] == 4'd0) ? 4'd9 : min_q[3:0] - 4'd1) : min_q[3:0];
    m1_dec = b2 ? ((min_q[7:4] == 4'd0) ? 4'd9 : min_q[7:4] - 4'd1) : min_q[7:4];
  end

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    // Only the highest-priority asserted input acts in a given cycle.
    if (load) begin
      if (!preset_ok) begin
        err_d = 1'b1;
      end else if (state_q != StRun) begin
        min_d   = preset_min;
        sec_d   = preset_sec;
        state_d = StIdle;
      end
    end else if (stop) begin
      if (state_q == StRun) state_d = StPause;
    end else if (start) begin
      if ((state_q == StIdle || state_q == StPause) && !count_zero) state_d = StRun;
    end else if (tick && state_q == StRun && !count_zero) begin
      min_d = {m1_dec, m0_dec};
      sec_d = {s1_dec, s0_dec};
      if (last_tick) begin
        state_d = StDone;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign q_min    = min_q;
  assign q_sec    = sec_q;
  assign running  = (state_q == StRun);
  assign done     = done_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_countdown_mmss.sv
// Randomized scoreboard bench for countdown_mmss: a seconds-based reference model predicts
// each cycle's outputs into a queue that a separate monitor pops and compares.
module tb_countdown_mmss;

  localparam logic [7:0] MAX_MIN = 8'h59;
  localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] preset_min = 8'h00, preset_sec = 8'h00;
  logic [7:0] q_min, q_sec;
  logic       running, done, load_err;

  countdown_mmss #(.MAX_MIN(MAX_MIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .preset_min (preset_min),
    .preset_sec (preset_sec),
    .start      (start),
    .stop       (stop),
    .q_min      (q_min),
    .q_sec      (q_sec),
    .running    (running),
    .done       (done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] qm;
    logic [7:0] qs;
    logic       run;
    logic       dn;
    logic       er;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model: count held as total seconds.
  int m_state = MIdle;
  int m_total = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic bit preset_valid(input logic [7:0] pm, input logic [7:0] ps);
    return (pm[7:4] <= 9) && (pm[3:0] <= 9) && (ps[7:4] <= 5) && (ps[3:0] <= 9) &&
           (pm <= MAX_MIN);
  endfunction

  task automatic cyc(input logic r, input logic l, input logic sp, input logic st,
                     input logic tk, input logic [7:0] pm, input logic [7:0] ps);
    exp_t e;
    bit   dn, er;
    @(negedge clk);
    reset = r; load = l; stop = sp; start = st; tick = tk;
    preset_min = pm; preset_sec = ps;
    dn = 0;
    er = 0;
    if (r) begin
      m_state = MIdle;
      m_total = 0;
    end else if (l) begin
      if (!preset_valid(pm, ps)) er = 1;
      else if (m_state != MRun) begin
        m_total = (pm[7:4] * 10 + pm[3:0]) * 60 + ps[7:4] * 10 + ps[3:0];
        m_state = MIdle;
      end
    end else if (sp) begin
      if (m_state == MRun) m_state = MPause;
    end else if (st) begin
      if ((m_state == MIdle || m_state == MPause) && m_total != 0) m_state = MRun;
    end else if (tk && m_state == MRun && m_total > 0) begin
      m_total--;
      if (m_total == 0) begin
        m_state = MDone;
        dn = 1;
      end
    end
    e.qm  = to_bcd(m_total / 60);
    e.qs  = to_bcd(m_total % 60);
    e.run = (m_state == MRun);
    e.dn  = dn;
    e.er  = er;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 8'h00, 8'h00);
  endtask

  // Monitor: outputs are registered, so every post-edge sample is a presented response.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (q_min === e.qm && q_sec === e.qs && running === e.run && done === e.dn &&
          load_err === e.er) begin
        n_pass++;
      end else begin
        $display("FAIL cycle_outputs t=%0t got q=%h:%h run=%b done=%b err=%b want q=%h:%h run=%b done=%b err=%b",
                 $time, q_min, q_sec, running, done, load_err,
                 e.qm, e.qs, e.run, e.dn, e.er);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] a, b, c, d;
    logic [7:0] pm, ps;
    bit         rr, ll, pp, ss, tt;

    cyc(1, 0, 0, 0, 0, 8'h00, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00, 8'h00);
    // Idle after reset: start at 00:00 is ignored.
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00);
    ticks(2);

    // 01:00 down to 00:00 with full borrow on the first tick.
    cyc(0, 1, 0, 0, 0, 8'h01, 8'h00);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00);
    ticks(1);
    ticks(59);
    ticks(2);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00);

    // Pause/resume.
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h10);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00);
    ticks(3);
    cyc(0, 0, 1, 0, 0, 8'h00, 8'h00);
    ticks(5);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00);
    ticks(1);

    // Rejected loads, and a load while running.
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h60);
    idle(1);
    cyc(0, 1, 0, 0, 0, 8'h1A, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h60, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h02, 8'h00);
    cyc(0, 0, 1, 0, 0, 8'h00, 8'h00);

    // Stop+start+tick together from RUN at 00:05.
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h05);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00);
    cyc(0, 0, 1, 1, 1, 8'h00, 8'h00);
    cyc(0, 0, 1, 1, 0, 8'h00, 8'h00);

    // Reset with tick from RUN at 10:00.
    cyc(0, 1, 0, 0, 0, 8'h10, 8'h00);
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00);
    cyc(1, 1, 0, 1, 1, 8'h05, 8'h05);
    idle(1);

    for (int i = 0; i < 4000; i++) begin
      a = 4'($urandom_range(0, 1));
      b = 4'($urandom_range(0, 9));
      c = 4'($urandom_range(0, 5));
      d = 4'($urandom_range(0, 9));
      pm = {a, b};
      ps = {c, d};
      if ($urandom_range(0, 3) == 0) begin
        pm = 8'($urandom);
        ps = 8'($urandom);
      end
      rr = ($urandom_range(0, 299) == 0);
      ll = ($urandom_range(0, 29) == 0);
      pp = ($urandom_range(0, 39) == 0);
      ss = ($urandom_range(0, 7) == 0);
      tt = ($urandom_range(0, 1) == 0);
      cyc(rr, ll, pp, ss, tt, pm, ps);
    end

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
